// File: rtl/crm_store.sv
// Control-RAM storage stage: registered microword read with write-first merge,
// diagnostic slice write/verify FSM, per-slice parity and EBUS readback.
module crm_store #(
   parameter int ADR_WIDTH   = 11,
   parameter int SLICE_WIDTH = 20,
   parameter int SLICES      = 4
) (
   input  logic                          clk,
   input  logic                          RESET_N,
   input  logic [ADR_WIDTH-1:0]          CRADR,
   input  logic [SLICES-1:0]             DIAG_WR_EN,
   input  logic [SLICE_WIDTH-1:0]        DIAG_DATA,
   input  logic                          PAR_INJECT,
   input  logic                          DIAG_RD_EN,
   input  logic [1:0]                    DIAG_RD_SEL,
   input  logic                          PAR_ERR_CLR,
   output logic [SLICES*SLICE_WIDTH-1:0] CRAM_WORD,
   output logic                          PAR_ERR,
   output logic                          WR_ERR,
   output logic                          OVERRUN,
   output logic                          BUSY,
   output logic                          EBUS_DRIVING,
   output logic [SLICE_WIDTH-1:0]        EBUS_DATA
);

   localparam int DEPTH = 1 << ADR_WIDTH;
   localparam int WW    = SLICES * SLICE_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY} state_e;

   state_e                 state_q, state_d;
   logic [ADR_WIDTH-1:0]   adr_q, adr_d;
   logic [SLICES-1:0]      mask_q, mask_d;
   logic [SLICE_WIDTH-1:0] data_q, data_d;
   logic                   inj_q, inj_d;
   logic [WW-1:0]          cram_q, cram_d;
   logic [SLICES-1:0]      par_q, par_d;
   logic                   perr_q, perr_d;
   logic                   werr_q, werr_d;
   logic                   ovr_q, ovr_d;

   // Slice data in the low bits, stored parity in the top bit.
   logic [SLICE_WIDTH:0]   mem_q [SLICES][DEPTH];
   logic [SLICE_WIDTH:0]   rd_slc [SLICES];
   logic [SLICE_WIDTH:0]   wr_slc;
   logic                   wr_go;
   logic                   busy;
   logic                   par_mis;
   logic                   vfy_bad;

   assign wr_go  = (state_q == S_WRITE);
   assign busy   = (state_q != S_IDLE);
   assign wr_slc = {(^data_q) ^ inj_q, data_q};

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      mask_d  = mask_q;
      data_d  = data_q;
      inj_d   = inj_q;
      unique case (state_q)
         S_IDLE: begin
            if (|DIAG_WR_EN) begin
               adr_d   = CRADR;
               mask_d  = DIAG_WR_EN;
               data_d  = DIAG_DATA;
               inj_d   = PAR_INJECT;
               state_d = S_WRITE;
            end
         end
         S_WRITE:  state_d = S_VERIFY;
         S_VERIFY: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cram_d = '0;
      par_d  = '0;
      for (int s = 0; s < SLICES; s++) begin
         rd_slc[s] = mem_q[s][CRADR];
         if (wr_go && (adr_q == CRADR) && mask_q[s])
            rd_slc[s] = wr_slc;
         cram_d[s*SLICE_WIDTH +: SLICE_WIDTH] = rd_slc[s][SLICE_WIDTH-1:0];
         par_d[s] = rd_slc[s][SLICE_WIDTH];
      end
   end

   always_comb begin
      par_mis = 1'b0;
      vfy_bad = 1'b0;
      for (int s = 0; s < SLICES; s++) begin
         if ((^cram_q[s*SLICE_WIDTH +: SLICE_WIDTH]) != par_q[s])
            par_mis = 1'b1;
         if ((state_q == S_VERIFY) && mask_q[s] &&
             (mem_q[s][adr_q][SLICE_WIDTH-1:0] != data_q))
            vfy_bad = 1'b1;
      end
   end

   // A set in the same cycle as a clear wins.
   assign perr_d = par_mis | (perr_q & ~PAR_ERR_CLR);
   assign werr_d = vfy_bad | (werr_q & ~PAR_ERR_CLR);
   assign ovr_d  = (busy & (|DIAG_WR_EN)) | (ovr_q & ~PAR_ERR_CLR);

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         adr_q   <= '0;
         mask_q  <= '0;
         data_q  <= '0;
         inj_q   <= 1'b0;
         cram_q  <= '0;
         par_q   <= '0;
         perr_q  <= 1'b0;
         werr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         mask_q  <= mask_d;
         data_q  <= data_d;
         inj_q   <= inj_d;
         cram_q  <= cram_d;
         par_q   <= par_d;
         perr_q  <= perr_d;
         werr_q  <= werr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_go) begin
         for (int s = 0; s < SLICES; s++) begin
            if (mask_q[s])
               mem_q[s][adr_q] <= wr_slc;
         end
      end
   end

   assign CRAM_WORD    = cram_q;
   assign PAR_ERR      = perr_q;
   assign WR_ERR       = werr_q;
   assign OVERRUN      = ovr_q;
   assign BUSY         = busy;
   assign EBUS_DRIVING = DIAG_RD_EN;
   assign EBUS_DATA    = DIAG_RD_EN ?
                         mem_q[DIAG_RD_SEL][CRADR][SLICE_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_crm_store.sv
// Scoreboard bench for crm_store: stimulus task pushes model predictions,
// an independent monitor pops and compares one entry per clock.
module tb_crm_store;

   logic        clk;
   logic        RESET_N;
   logic [10:0] CRADR;
   logic [3:0]  DIAG_WR_EN;
   logic [19:0] DIAG_DATA;
   logic        PAR_INJECT;
   logic        DIAG_RD_EN;
   logic [1:0]  DIAG_RD_SEL;
   logic        PAR_ERR_CLR;
   logic [79:0] CRAM_WORD;
   logic        PAR_ERR;
   logic        WR_ERR;
   logic        OVERRUN;
   logic        BUSY;
   logic        EBUS_DRIVING;
   logic [19:0] EBUS_DATA;

   crm_store dut (
      .clk          (clk),
      .RESET_N      (RESET_N),
      .CRADR        (CRADR),
      .DIAG_WR_EN   (DIAG_WR_EN),
      .DIAG_DATA    (DIAG_DATA),
      .PAR_INJECT   (PAR_INJECT),
      .DIAG_RD_EN   (DIAG_RD_EN),
      .DIAG_RD_SEL  (DIAG_RD_SEL),
      .PAR_ERR_CLR  (PAR_ERR_CLR),
      .CRAM_WORD    (CRAM_WORD),
      .PAR_ERR      (PAR_ERR),
      .WR_ERR       (WR_ERR),
      .OVERRUN      (OVERRUN),
      .BUSY         (BUSY),
      .EBUS_DRIVING (EBUS_DRIVING),
      .EBUS_DATA    (EBUS_DATA)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [79:0] word;
      logic        par;
      logic        wr;
      logic        ovr;
      logic        busy;
      logic        drv;
      logic [19:0] ebus;
   } exp_t;

   exp_t q[$];
   int   n_cmp;
   int   n_bad;

   // Reference model: word contents as plain arrays, write as a 2-cycle job.
   logic [19:0] m_data [0:8191];
   bit          m_bad  [0:8191];
   int          m_left;
   logic [10:0] p_addr;
   logic [3:0]  p_mask;
   logic [19:0] p_data;
   bit          p_inj;
   bit          m_cur_bad;
   bit          m_par, m_wr, m_ovr;

   task automatic chk(input string name, input logic [79:0] act,
                      input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [10:0] a, input logic [3:0] we,
                       input logic [19:0] d, input logic inj,
                       input logic rde, input logic [1:0] sel,
                       input logic clr, input logic rn);
      logic  was_rn;
      bit    busy_before;
      exp_t  e;
      was_rn      = RESET_N;
      CRADR       = a;
      DIAG_WR_EN  = we;
      DIAG_DATA   = d;
      PAR_INJECT  = inj;
      DIAG_RD_EN  = rde;
      DIAG_RD_SEL = sel;
      PAR_ERR_CLR = clr;
      RESET_N     = rn;
      #1;
      if (!rn && was_rn) begin
         chk("rst_async_word", CRAM_WORD, 80'h0);
         chk("rst_async_busy", {79'h0, BUSY}, 80'h0);
      end
      @(posedge clk);
      if (!rn) begin
         m_left    = 0;
         m_cur_bad = 0;
         m_par     = 0;
         m_wr      = 0;
         m_ovr     = 0;
         e.word    = '0;
      end else begin
         busy_before = (m_left > 0);
         if (m_left == 2) begin
            for (int s = 0; s < 4; s++) begin
               if (p_mask[s]) begin
                  m_data[int'(p_addr)*4+s] = p_data;
                  m_bad[int'(p_addr)*4+s]  = p_inj;
               end
            end
         end
         m_par = (m_par && !clr) || m_cur_bad;
         m_ovr = (m_ovr && !clr) || (busy_before && we != 0);
         m_wr  = m_wr && !clr;
         if (m_left == 0 && we != 0) begin
            p_addr = a;
            p_mask = we;
            p_data = d;
            p_inj  = inj;
            m_left = 2;
         end else if (m_left > 0) begin
            m_left--;
         end
         m_cur_bad = 0;
         for (int s = 0; s < 4; s++) begin
            e.word[s*20 +: 20] = m_data[int'(a)*4+s];
            if (m_bad[int'(a)*4+s]) m_cur_bad = 1;
         end
      end
      e.par  = m_par;
      e.wr   = m_wr;
      e.ovr  = m_ovr;
      e.busy = (m_left > 0);
      e.drv  = rde;
      e.ebus = rde ? m_data[int'(a)*4+int'(sel)] : 20'h0;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic [10:0] a);
      for (int i = 0; i < n; i++) step(a, 4'h0, 20'h0, 0, 0, 2'd0, 0, 1);
   endtask

   task automatic rd(input logic [10:0] a, input logic [1:0] sel);
      step(a, 4'h0, 20'h0, 0, 1, sel, 0, 1);
   endtask

   bit done;

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("mon_word",  CRAM_WORD,              e.word);
            chk("mon_perr",  {79'h0, PAR_ERR},       {79'h0, e.par});
            chk("mon_werr",  {79'h0, WR_ERR},        {79'h0, e.wr});
            chk("mon_ovr",   {79'h0, OVERRUN},       {79'h0, e.ovr});
            chk("mon_busy",  {79'h0, BUSY},          {79'h0, e.busy});
            chk("mon_drv",   {79'h0, EBUS_DRIVING},  {79'h0, e.drv});
            chk("mon_ebus",  {60'h0, EBUS_DATA},     {60'h0, e.ebus});
         end
      end
   end

   initial begin : stim
      logic [10:0] a;
      logic [3:0]  we;
      for (int i = 0; i < 8192; i++) begin
         m_data[i] = '0;
         m_bad[i]  = 0;
      end
      m_left = 0; m_cur_bad = 0; m_par = 0; m_wr = 0; m_ovr = 0;
      p_addr = '0; p_mask = '0; p_data = '0; p_inj = 0;
      n_cmp = 0; n_bad = 0; done = 0;
      RESET_N = 1'b0;

      step(11'h000, 4'h0, 20'h0, 0, 0, 2'd0, 0, 0);
      step(11'h000, 4'h0, 20'h0, 0, 0, 2'd0, 0, 0);
      idle(1, 11'h000);
      chk("reset_word", CRAM_WORD, 80'h0);
      chk("reset_perr", {79'h0, PAR_ERR}, 80'h0);
      chk("reset_busy", {79'h0, BUSY}, 80'h0);
      idle(10, 11'h000);
      chk("idle_flags", {77'h0, PAR_ERR, WR_ERR, OVERRUN}, 80'h0);

      step(11'h155, 4'b0001, 20'hABCDE, 0, 0, 2'd0, 0, 1);
      chk("busy_after_strobe", {79'h0, BUSY}, 80'h1);
      idle(2, 11'h155);
      rd(11'h155, 2'd0);
      chk("word_155_s0", {60'h0, CRAM_WORD[19:0]}, 80'hABCDE);
      chk("word_155_rest", {20'h0, CRAM_WORD[79:20]}, 80'h0);
      chk("ebus_155_s0", {60'h0, EBUS_DATA}, 80'hABCDE);

      step(11'h7FF, 4'b1010, 20'h12345, 0, 0, 2'd0, 0, 1);
      idle(2, 11'h7FF);
      rd(11'h7FF, 2'd1);
      chk("ebus_7ff_s1", {60'h0, EBUS_DATA}, 80'h12345);
      rd(11'h7FF, 2'd3);
      chk("ebus_7ff_s3", {60'h0, EBUS_DATA}, 80'h12345);
      chk("word_7ff", CRAM_WORD, {20'h12345, 20'h0, 20'h12345, 20'h0});
      chk("werr_7ff", {79'h0, WR_ERR}, 80'h0);

      step(11'h010, 4'b0001, 20'h00001, 1, 0, 2'd0, 0, 1);
      idle(3, 11'h000);
      idle(1, 11'h010);
      chk("perr_1clk", {79'h0, PAR_ERR}, 80'h0);
      idle(1, 11'h010);
      chk("perr_2clk", {79'h0, PAR_ERR}, 80'h1);
      idle(1, 11'h000);
      step(11'h000, 4'h0, 20'h0, 0, 0, 2'd0, 1, 1);
      chk("perr_clr", {79'h0, PAR_ERR}, 80'h0);
      idle(3, 11'h000);
      chk("perr_stays_clr", {79'h0, PAR_ERR}, 80'h0);

      step(11'h020, 4'b0001, 20'h0AAAA, 0, 0, 2'd0, 0, 1);
      step(11'h020, 4'b0001, 20'h05555, 0, 0, 2'd0, 0, 1);
      idle(2, 11'h020);
      rd(11'h020, 2'd0);
      chk("ovr_set", {79'h0, OVERRUN}, 80'h1);
      chk("ovr_first_data", {60'h0, EBUS_DATA}, 80'h0AAAA);
      step(11'h020, 4'h0, 20'h0, 0, 0, 2'd0, 1, 1);

      step(11'h030, 4'b1111, 20'hFEDCB, 0, 0, 2'd0, 0, 1);
      step(11'h030, 4'h0, 20'h0, 0, 0, 2'd0, 0, 0);
      idle(1, 11'h030);
      rd(11'h030, 2'd2);
      chk("abort_ebus", {60'h0, EBUS_DATA}, 80'h0);
      chk("abort_word", CRAM_WORD, 80'h0);
      chk("abort_busy", {79'h0, BUSY}, 80'h0);

      for (int i = 0; i < 800; i++) begin
         case ($urandom_range(0, 5))
            0: a = 11'h000;
            1: a = 11'h010;
            2: a = 11'h155;
            3: a = 11'h7FF;
            4: a = 11'h030;
            default: a = 11'($urandom_range(0, 2047));
         endcase
         we = ($urandom_range(0, 9) < 3) ? 4'($urandom) : 4'h0;
         step(a, we, 20'($urandom), $urandom_range(0, 9) == 0,
              1'($urandom), 2'($urandom), $urandom_range(0, 9) == 0,
              $urandom_range(0, 99) != 0);
      end
      idle(2, 11'h000);

      for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
      #2;
      chk("queue_drained", 80'(q.size()), 80'h0);
      done = 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
